// File: rtl/instruction_fetch_queue.sv
// Instruction fetch queue for the MIPS pipeline.
// Reads a synchronous 1-cycle ROM, buffers {PC, word} pairs in a small
// circular FIFO and hands the head to decode over valid/ready.
// Optional performance counters are enabled with `define IFQ_PERF_COUNTERS_EN.
module instruction_fetch_queue #(
  parameter int PC_WIDTH    = 10,
  parameter int INSTR_WIDTH = 32,
  parameter int QUEUE_DEPTH = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clkEnable,
  input  logic                   branchFlag,
  input  logic [PC_WIDTH-1:0]    branchPC,
  input  logic                   jumpFlag,
  input  logic [PC_WIDTH-1:0]    jumpPC,
  output logic [PC_WIDTH-1:0]    memAddr,
  output logic                   memReq,
  input  logic [INSTR_WIDTH-1:0] memData,
  output logic [INSTR_WIDTH-1:0] Instruction,
  output logic [PC_WIDTH-1:0]    PC,
  output logic                   instrValid,
  input  logic                   instrReady
`ifdef IFQ_PERF_COUNTERS_EN
  ,
  output logic [31:0]            fetchCount,
  output logic [15:0]            flushCount,
  output logic [31:0]            stallCount
`endif
);

  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

  logic [PC_WIDTH-1:0]    fetchPC;
  logic                   inflight;
  logic [PC_WIDTH-1:0]    inflightPC;
  logic [PTR_W-1:0]       rdPtr;
  logic [PTR_W-1:0]       wrPtr;
  logic [CNT_W-1:0]       count;
  logic                   holdValid;
  logic [INSTR_WIDTH-1:0] holdData;
  logic [PC_WIDTH-1:0]    pcMem    [QUEUE_DEPTH];
  logic [INSTR_WIDTH-1:0] instrMem [QUEUE_DEPTH];

  logic                   redirect;
  logic [PC_WIDTH-1:0]    target;
  logic [CNT_W:0]         occupancy;
  logic                   hasCredit;
  logic                   issue;
  logic                   push;
  logic                   pop;
  logic [INSTR_WIDTH-1:0] respData;

  // Redirect selection, credit accounting and handshake decode
  always_comb begin
    redirect  = branchFlag || jumpFlag;
    target    = branchFlag ? branchPC : jumpPC;
    occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
    hasCredit = occupancy < (CNT_W+1)'(QUEUE_DEPTH);
    issue     = reset && clkEnable && !redirect && hasCredit;
    push      = inflight && !redirect;
    instrValid = (count != '0);
    pop       = instrValid && instrReady;
    respData  = holdValid ? holdData : memData;
  end

  assign memReq      = issue;
  assign memAddr     = fetchPC;
  assign Instruction = instrValid ? instrMem[rdPtr] : '0;
  assign PC          = instrValid ? pcMem[rdPtr]    : '0;

  // Fetch pointer, in-flight tracking, queue pointers and the stall-time data capture
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetchPC    <= RESET_PC;
      inflight   <= 1'b0;
      inflightPC <= '0;
      rdPtr      <= '0;
      wrPtr      <= '0;
      count      <= '0;
      holdValid  <= 1'b0;
      holdData   <= '0;
    end else if (!clkEnable) begin
      if (inflight && !holdValid) begin
        holdValid <= 1'b1;
        holdData  <= memData;
      end
    end else begin
      holdValid <= 1'b0;
      if (redirect) begin
        fetchPC  <= target;
        inflight <= 1'b0;
        rdPtr    <= '0;
        wrPtr    <= '0;
        count    <= '0;
      end else begin
        inflight <= issue;
        if (issue) begin
          inflightPC <= fetchPC;
          fetchPC    <= fetchPC + PC_WIDTH'(1);
        end
        if (push) wrPtr <= wrPtr + PTR_W'(1);
        if (pop)  rdPtr <= rdPtr + PTR_W'(1);
        if (push && !pop)      count <= count + CNT_W'(1);
        else if (!push && pop) count <= count - CNT_W'(1);
      end
    end
  end

  // Queue storage written with the returning ROM word and its PC
  always_ff @(posedge clk) begin
    if (reset && clkEnable && push) begin
      pcMem[wrPtr]    <= inflightPC;
      instrMem[wrPtr] <= respData;
    end
  end

`ifdef IFQ_PERF_COUNTERS_EN
  // Accepted pops, flushes that actually drop work, and decode stall cycles
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetchCount <= '0;
      flushCount <= '0;
      stallCount <= '0;
    end else if (clkEnable) begin
      if (pop) fetchCount <= fetchCount + 32'd1;
      if (redirect && (inflight || (count != '0 && !(pop && count == CNT_W'(1)))))
        flushCount <= flushCount + 16'd1;
      if (instrValid && !instrReady) stallCount <= stallCount + 32'd1;
    end
  end
`else
  // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Self-checking bench for instruction_fetch_queue with a ROM[i]=i model
// and a scoreboard of expected head PCs.
module tb_instruction_fetch_queue;

  localparam int PW = 10;
  localparam int IW = 32;
  localparam int QD = 4;

  logic          clk = 1'b0;
  logic          reset, clkEnable, branchFlag, jumpFlag, instrReady;
  logic [PW-1:0] branchPC, jumpPC, memAddr, PC;
  logic          memReq, instrValid;
  logic [IW-1:0] memData, Instruction;
`ifdef IFQ_PERF_COUNTERS_EN
  logic [31:0]   fetchCount, stallCount;
  logic [15:0]   flushCount;
`endif

  int checks = 0;
  int failures = 0;
  int popCount = 0;
  int base;
  int reqs;
  logic [PW-1:0] sb[$];

  instruction_fetch_queue #(
    .PC_WIDTH(PW), .INSTR_WIDTH(IW), .QUEUE_DEPTH(QD), .RESET_PC('0)
  ) dut (
    .clk(clk), .reset(reset), .clkEnable(clkEnable),
    .branchFlag(branchFlag), .branchPC(branchPC),
    .jumpFlag(jumpFlag), .jumpPC(jumpPC),
    .memAddr(memAddr), .memReq(memReq), .memData(memData),
    .Instruction(Instruction), .PC(PC),
    .instrValid(instrValid), .instrReady(instrReady)
`ifdef IFQ_PERF_COUNTERS_EN
    , .fetchCount(fetchCount), .flushCount(flushCount), .stallCount(stallCount)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous ROM holding ROM[i]=i; returns junk when not read so held data is exercised
  always @(posedge clk) begin
    if (memReq) memData <= IW'(memAddr);
    else        memData <= 32'hDEAD_BEEF;
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic en, input logic bf,
                               input logic [PW-1:0] bpc, input logic jf,
                               input logic [PW-1:0] jpc, input logic rdy);
    reset      = rst;
    clkEnable  = en;
    branchFlag = bf;
    branchPC   = bpc;
    jumpFlag   = jf;
    jumpPC     = jpc;
    instrReady = rdy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushStream(input logic [PW-1:0] start, input int n);
    sb.delete();
    for (int i = 0; i < n; i++) sb.push_back(start + PW'(i));
  endtask

  // Every accepted head is compared against the next expected PC and its ROM word
  always @(negedge clk) begin
    logic [PW-1:0] exp;
    if (reset && clkEnable && instrValid && instrReady) begin
      checkOutput("sbNotEmpty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        exp = sb.pop_front();
        checkOutput("headPC", 64'(PC), 64'(exp));
        checkOutput("headInstr", 64'(Instruction), 64'(IW'(exp)));
      end
      popCount++;
    end
  end

  initial begin
    // Reset state, latency and streaming rate
    applyStimulus(0, 1, 0, '0, 0, '0, 1);
    repeat (3) tick();
    checkOutput("rstValid", 64'(instrValid), 64'd0);
    checkOutput("rstInstr", 64'(Instruction), 64'd0);
    checkOutput("rstPC", 64'(PC), 64'd0);
    checkOutput("rstReq", 64'(memReq), 64'd0);
    pushStream('0, 64);
    applyStimulus(1, 1, 0, '0, 0, '0, 1);
    checkOutput("firstReq", 64'(memReq), 64'd1);
    checkOutput("firstAddr", 64'(memAddr), 64'd0);
    tick();
    checkOutput("validAfter1", 64'(instrValid), 64'd0);
    tick();
    checkOutput("validAfter2", 64'(instrValid), 64'd1);
    checkOutput("firstPC", 64'(PC), 64'd0);
    base = popCount;
    repeat (10) tick();
    checkOutput("steadyRate", 64'(popCount - base), 64'd10);

    // Decode stalled from reset: exactly QD reads, then drain in order
    applyStimulus(0, 1, 0, '0, 0, '0, 0);
    repeat (2) tick();
    pushStream('0, 64);
    applyStimulus(1, 1, 0, '0, 0, '0, 0);
    reqs = 0;
    for (int i = 0; i < 10; i++) begin
      if (memReq) begin
        checkOutput("stallAddr", 64'(memAddr), 64'(reqs));
        reqs++;
      end
      tick();
    end
    checkOutput("stallReqs", 64'(reqs), 64'(QD));
    checkOutput("fullNoReq", 64'(memReq), 64'd0);
    checkOutput("fullValid", 64'(instrValid), 64'd1);
    checkOutput("fullHeadPC", 64'(PC), 64'd0);
    applyStimulus(1, 1, 0, '0, 0, '0, 1);
    base = popCount;
    repeat (8) tick();
    checkOutput("drainRate", 64'(popCount - base), 64'd8);

    // Branch with three queued entries and one in flight
    applyStimulus(0, 1, 0, '0, 0, '0, 0);
    tick();
    pushStream('0, 64);
    applyStimulus(1, 1, 0, '0, 0, '0, 0);
    repeat (4) tick();
    checkOutput("preBranchReq", 64'(memReq), 64'd0);
    checkOutput("preBranchPC", 64'(PC), 64'd0);
    applyStimulus(1, 1, 1, 10'h200, 0, '0, 0);
    checkOutput("redirReq", 64'(memReq), 64'd0);
    tick();
    pushStream(10'h200, 64);
    applyStimulus(1, 1, 0, '0, 0, '0, 1);
    checkOutput("flushValid", 64'(instrValid), 64'd0);
    checkOutput("branchReq", 64'(memReq), 64'd1);
    checkOutput("branchAddr", 64'(memAddr), 64'h200);
`ifdef IFQ_PERF_COUNTERS_EN
    checkOutput("flushCount", 64'(flushCount), 64'd1);
`endif
    tick();
    checkOutput("branchValid1", 64'(instrValid), 64'd0);
    tick();
    checkOutput("branchValid2", 64'(instrValid), 64'd1);
    checkOutput("branchHeadPC", 64'(PC), 64'h200);
    repeat (4) tick();

    // Branch and jump together: branch wins
    applyStimulus(1, 1, 1, 10'h010, 1, 10'h100, 1);
    tick();
    pushStream(10'h010, 64);
    applyStimulus(1, 1, 0, '0, 0, '0, 1);
    checkOutput("prioAddr", 64'(memAddr), 64'h010);
    tick();
    tick();
    checkOutput("prioValid", 64'(instrValid), 64'd1);
    checkOutput("prioHeadPC", 64'(PC), 64'h010);
    repeat (3) tick();

    // Enable dropped with one entry queued and one read in flight
    applyStimulus(1, 1, 1, 10'h050, 0, '0, 0);
    tick();
    pushStream(10'h050, 64);
    applyStimulus(1, 1, 0, '0, 0, '0, 0);
    checkOutput("enAddr", 64'(memAddr), 64'h050);
    repeat (2) tick();
    applyStimulus(1, 0, 0, '0, 0, '0, 1);
    for (int i = 0; i < 5; i++) begin
      checkOutput("frozenReq", 64'(memReq), 64'd0);
      checkOutput("frozenValid", 64'(instrValid), 64'd1);
      checkOutput("frozenPC", 64'(PC), 64'h050);
      checkOutput("frozenInstr", 64'(Instruction), 64'h050);
      tick();
    end
    applyStimulus(1, 1, 0, '0, 0, '0, 1);
    checkOutput("resumeReq", 64'(memReq), 64'd1);
    checkOutput("resumeAddr", 64'(memAddr), 64'h052);
    base = popCount;
    repeat (6) tick();
    checkOutput("resumeRate", 64'(popCount - base), 64'd6);

    // PC wrap at the top of the address space
    applyStimulus(1, 1, 1, 10'h3FD, 0, '0, 1);
    tick();
    pushStream(10'h3FD, 64);
    applyStimulus(1, 1, 0, '0, 0, '0, 1);
    repeat (2) tick();
    checkOutput("wrapStartPC", 64'(PC), 64'h3FD);
    repeat (3) tick();
    checkOutput("wrapPC", 64'(PC), 64'h000);
    repeat (3) tick();

    // Reset with a full queue restarts fetch at RESET_PC
    applyStimulus(1, 1, 0, '0, 0, '0, 0);
    repeat (6) tick();
    checkOutput("preRstFullReq", 64'(memReq), 64'd0);
    checkOutput("preRstValid", 64'(instrValid), 64'd1);
    applyStimulus(0, 1, 0, '0, 0, '0, 0);
    checkOutput("inRstReq", 64'(memReq), 64'd0);
    tick();
    checkOutput("postRstValid", 64'(instrValid), 64'd0);
    checkOutput("postRstPC", 64'(PC), 64'd0);
    checkOutput("postRstInstr", 64'(Instruction), 64'd0);
    pushStream('0, 64);
    applyStimulus(1, 1, 0, '0, 0, '0, 1);
    checkOutput("restartReq", 64'(memReq), 64'd1);
    checkOutput("restartAddr", 64'(memAddr), 64'd0);
    repeat (2) tick();
    checkOutput("restartValid", 64'(instrValid), 64'd1);
    checkOutput("restartPC", 64'(PC), 64'd0);
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
